// File: rtl/regfile_4bit.sv
// Purpose: 8-entry x 4-bit register file, one write port, two registered read ports, same-cycle write forwarding.
// Latency: writes land on the next edge; read data and rvalid appear one cycle after a read request.
// Backpressure: none; accepts one read pair and one write every cycle.
module regfile_4bit #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_q,  rvalid_d;

  // Next read data: a write to the same address this cycle wins over stale storage, per port.
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    rvalid_d  = re;
    if (re) begin
      rdata_a_d = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
      rdata_b_d = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];
    end
  end

  // Storage and output registers; reset clears everything and blocks the write and read of that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Outputs come straight from flops so the downstream operand mux sees a clean register-to-output path.
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid  = rvalid_q;

endmodule
